// File: rtl/mmio_serial_out.sv
// Memory-mapped serial output port: a small byte FIFO fed by CPU stores,
// drained by an 8N1 UART transmitter, with a pollable status word.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line high, waiting for a queued byte
// START | start bit (line low) for one bit time
// DATA  | eight data bits, LSB first, one bit time each
// STOP  | stop bit (line high); chains straight into START if more queued
module mmio_serial_out #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [2:0] SEL_CODE     = 3'b101
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  select,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic          tx_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          overflow;

  logic          wr, push, pop, full, empty, bit_done;
  logic          unused_wdata;

  // Only the low byte of a store is transmitted.
  assign unused_wdata = ^wdata[31:8];

  assign wr       = we && (select == SEL_CODE);
  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign bit_done = (baud_cnt == '0);

  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign push = wr && (!full || pop);

  assign busy  = (state != IDLE) || !empty;
  assign rdata = (select == SEL_CODE) ? {28'h0, empty, overflow, full, busy} : 32'h0;

  // FIFO storage; pointers are reset elsewhere, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem[wr_ptr] <= wdata[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (wr && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Transmitter state, bit timer (down-counter), shifter and registered line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      tx       <= tx_next;
    end
  end

  // Next-state, FIFO pop and next line level; tx is derived from where the
  // FSM is heading so the line changes on the same edge as the state.
  always_comb begin
    state_next   = state;
    baud_next    = baud_cnt - CW'(1);
    bit_idx_next = bit_idx;
    shift_next   = shift;
    pop          = 1'b0;
    tx_next      = 1'b1;

    case (state)
      IDLE: begin
        baud_next = BAUD_LAST;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_next    = BAUD_LAST;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_next = BAUD_LAST;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            shift_next   = {1'b0, shift[7:1]};
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_next = BAUD_LAST;
          if (!empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_serial_out.sv
// Bench for mmio_serial_out: directed scenarios followed by random traffic,
// each cycle compared against a frame-position model of the UART port.
module tb_mmio_serial_out;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [2:0] SEL = 3'b101;

  logic        clk;
  logic        reset_n;
  logic [2:0]  select;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model: queue of accepted bytes plus the byte on the wire and how many
  // cycles into its 40-cycle frame the line is.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  bit         m_active;
  int         m_pos;
  bit         m_ovf;

  mmio_serial_out #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .SEL_CODE(SEL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .select(select),
    .we(we),
    .wdata(wdata),
    .rdata(rdata),
    .tx(tx),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic w, input logic [2:0] s, input logic [31:0] d,
                            input logic rn);
    bit wr_hit, pop, accept;
    if (!rn) begin
      m_q.delete();
      m_active = 0;
      m_pos    = 0;
      m_ovf    = 0;
      return;
    end
    wr_hit = w && (s == SEL);
    pop    = (!m_active || m_pos == FRAME - 1) && (m_q.size() > 0);
    accept = wr_hit && ((m_q.size() < DEPTH) || pop);
    if (wr_hit && !accept) m_ovf = 1;
    if (pop) begin
      m_cur    = m_q.pop_front();
      m_active = 1;
      m_pos    = 0;
    end else if (m_active) begin
      if (m_pos == FRAME - 1) m_active = 0;
      else m_pos++;
    end
    if (accept) m_q.push_back(d[7:0]);
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b - 1];
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic bsy, full, empty;
    bsy   = m_active || (m_q.size() > 0);
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    if (select != SEL) return 32'h0;
    return {28'h0, empty, m_ovf, full, bsy};
  endfunction

  task automatic step(input logic w, input logic [2:0] s, input logic [31:0] d,
                      input logic rn);
    we      = w;
    select  = s;
    wdata   = d;
    reset_n = rn;
    @(posedge clk);
    model_edge(w, s, d, rn);
    @(negedge clk);
    chk("tx", {31'h0, tx}, {31'h0, exp_tx()});
    chk("busy", {31'h0, busy}, {31'h0, (m_active || m_q.size() > 0)});
    chk("rdata", rdata, exp_rdata());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, (i % 2 == 0) ? SEL : 3'b001, 32'h0, 1'b1);
    step(1'b0, SEL, 32'h0, 1'b1);
  endtask

  initial begin
    we = 0; select = SEL; wdata = 0; reset_n = 0;
    m_active = 0; m_pos = 0; m_ovf = 0; m_cur = 0;

    // reset, including a write that reset must override
    step(1'b0, SEL, 32'h0, 1'b0);
    step(1'b1, SEL, 32'h0000_00AA, 1'b0);
    chk("reset_tx", {31'h0, tx}, 32'h1);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_status", rdata, 32'h8);
    step(1'b0, 3'b001, 32'h0, 1'b1);
    chk("other_select_rdata", rdata, 32'h0);
    idle(3);

    // single byte A5
    step(1'b1, SEL, 32'h0000_00A5, 1'b1);
    chk("busy_after_write", {31'h0, busy}, 32'h1);
    idle(45);
    chk("status_after_frame", rdata, 32'h8);

    // back-to-back frames
    step(1'b1, SEL, 32'h0000_0055, 1'b1);
    step(1'b1, SEL, 32'h0000_000F, 1'b1);
    idle(90);

    // six writes into a 4-deep FIFO: last one overflows
    for (int i = 1; i <= 6; i++) step(1'b1, SEL, i, 1'b1);
    chk("status_full_ovf", rdata, 32'h7);
    idle(5 * FRAME + 10);
    chk("status_ovf_sticky", rdata, 32'hC);

    // wrong slot: nothing accepted
    step(1'b0, SEL, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 3'b110, 32'hFF, 1'b1);
    chk("wrong_sel_busy", {31'h0, busy}, 32'h0);
    chk("wrong_sel_tx", {31'h0, tx}, 32'h1);
    idle(10);

    // reset in DATA bit 3 with two bytes queued
    step(1'b1, SEL, 32'h11, 1'b1);
    step(1'b1, SEL, 32'h22, 1'b1);
    step(1'b1, SEL, 32'h33, 1'b1);
    idle(15);
    chk("pre_reset_busy", {31'h0, busy}, 32'h1);
    step(1'b0, SEL, 32'h0, 1'b0);
    chk("midframe_reset_tx", {31'h0, tx}, 32'h1);
    chk("midframe_reset_busy", {31'h0, busy}, 32'h0);
    chk("midframe_reset_status", rdata, 32'h8);
    idle(60);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      logic       w, rn;
      logic [2:0] s;
      w  = ($urandom_range(0, 5) == 0);
      s  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : SEL;
      rn = ($urandom_range(0, 599) != 0);
      step(w, s, $urandom, rn);
    end
    idle(DEPTH * FRAME + FRAME + 5);
    chk("final_idle", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
